thermal_channel_tx: RTL and testbench

//  Transmit end of the temporal thermal covert channel. Sends one byte per request by on-off keying a bank of

---
 rtl/thermal_channel_pkg.sv | 23 ++
 rtl/thermal_heater_bank.sv | 38 +++
 rtl/thermal_channel_tx.sv | 126 ++++++++++++
 tb/tb_thermal_channel_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/thermal_channel_pkg.sv
// Constants shared by the thermal covert channel transmitter and receiver.
// One bit period is BIT_SECONDS of the 12 MHz system clock.
package thermal_channel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_GUARD    = 2'd3
    } tx_state_t;

    localparam int unsigned CLK_HZ           = 12_000_000;
    localparam int unsigned BIT_SECONDS      = 60;
    localparam int unsigned DEF_BIT_CYCLES   = CLK_HZ * BIT_SECONDS;
    localparam logic [7:0]  DEF_PREAMBLE     = 8'b0000_1010;
    localparam int          DEF_PREAMBLE_LEN = 4;

    // Left-justify the preamble so that it can be shifted out MSB first from bit 7.
    function automatic logic [7:0] align_preamble(input logic [7:0] pat, input int len);
        return pat << (8 - len);
    endfunction

endpackage

// File: rtl/thermal_heater_bank.sv
// Bank of toggling flops used as an on-chip heat source; the registered parity
// output gives every flop a fanout so synthesis keeps the whole bank.
module thermal_heater_bank
    import thermal_channel_pkg::*;
#(
    parameter int HEATER_WIDTH = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic parity
);

    logic [HEATER_WIDTH-1:0] bank;
    logic [HEATER_WIDTH-1:0] alt;
    logic                    primed;

    for (genvar g = 0; g < HEATER_WIDTH; g++) begin : g_alt
        assign alt[g] = (g % 2 == 1);
    end

    // The first enabled cycle seeds a 0/1 pattern so neighbouring flops switch
    // in opposite directions from then on.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank   <= '0;
            primed <= 1'b0;
            parity <= 1'b0;
        end else begin
            parity <= ^bank;
            if (enable) begin
                bank   <= primed ? ~bank : alt;
                primed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/thermal_channel_tx.sv
// Transmit end of the thermal covert channel: on-off keys the heater bank with
// a preamble, one data byte MSB first, then one cold guard period.
module thermal_channel_tx
    import thermal_channel_pkg::*;
#(
    parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int          HEATER_WIDTH = 1024,
    parameter logic [7:0]  PREAMBLE     = DEF_PREAMBLE,
    parameter int          PREAMBLE_LEN = DEF_PREAMBLE_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       abort,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       heater_on,
    output logic [3:0] bit_index,
    output logic       heater_parity,
    output logic [7:0] leds
);

    localparam logic [31:0] CNT_LAST = 32'(BIT_CYCLES - 1);
    localparam logic [7:0]  PRE_INIT = align_preamble(PREAMBLE, PREAMBLE_LEN);
    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN - 1);

    tx_state_t   state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [3:0]  bidx_n;
    logic [7:0]  sh, sh_n;
    logic [7:0]  data_q, data_n;
    logic        accept, wrap;

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = tx_valid & tx_ready & ~abort;
    assign wrap     = (cnt == CNT_LAST);

    // sh always holds the bit on air in bit 7: preamble first, then the data byte.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bidx_n  = bit_index;
        sh_n    = sh;
        data_n  = data_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_PREAMBLE;
                    cnt_n   = '0;
                    bidx_n  = '0;
                    sh_n    = PRE_INIT;
                    data_n  = tx_data;
                end
            end
            default: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    bidx_n  = '0;
                end else if (!wrap) begin
                    cnt_n = cnt + 32'd1;
                end else begin
                    cnt_n = '0;
                    case (state)
                        ST_PREAMBLE: begin
                            if (bit_index == PRE_LAST) begin
                                state_n = ST_DATA;
                                bidx_n  = '0;
                                sh_n    = data_q;
                            end else begin
                                bidx_n = bit_index + 4'd1;
                                sh_n   = {sh[6:0], 1'b0};
                            end
                        end
                        ST_DATA: begin
                            if (bit_index == 4'd7) begin
                                state_n = ST_GUARD;
                                bidx_n  = '0;
                            end else begin
                                bidx_n = bit_index + 4'd1;
                                sh_n   = {sh[6:0], 1'b0};
                            end
                        end
                        default: state_n = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_index <= '0;
            sh        <= '0;
            data_q    <= '0;
            heater_on <= 1'b0;
            done      <= 1'b0;
            leds      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_index <= bidx_n;
            sh        <= sh_n;
            data_q    <= data_n;
            heater_on <= ((state_n == ST_PREAMBLE) || (state_n == ST_DATA)) && sh_n[7];
            done      <= (state_n == ST_GUARD) && (cnt_n == CNT_LAST);
            leds      <= (state_n == ST_IDLE) ? 8'h00 : data_n;
        end
    end

    thermal_heater_bank #(
        .HEATER_WIDTH(HEATER_WIDTH)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .enable(heater_on),
        .parity(heater_parity)
    );

endmodule

// File: tb/tb_thermal_channel_tx.sv
// Randomised frame stimulus with a queue of expected frames; a negedge monitor
// rebuilds each frame's keyed waveform from its byte and checks every cycle.
module tb_thermal_channel_tx;

    localparam int         BC   = 4;
    localparam int         HW   = 8;
    localparam int         PLEN = 4;
    localparam logic [7:0] PRE  = 8'b0000_1010;
    localparam int         T    = (PLEN + 9) * BC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       abort = 1'b0;
    logic       tx_ready, busy, done, heater_on, heater_parity;
    logic [3:0] bit_index;
    logic [7:0] leds;

    thermal_channel_tx #(
        .BIT_CYCLES  (BC),
        .HEATER_WIDTH(HW),
        .PREAMBLE    (PRE),
        .PREAMBLE_LEN(PLEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .abort        (abort),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done),
        .heater_on    (heater_on),
        .bit_index    (bit_index),
        .heater_parity(heater_parity),
        .leds         (leds)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_s = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
    end

    typedef struct {
        int         acc;
        logic [7:0] d;
        int         fin;
    } frame_t;

    frame_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    logic [HW-1:0] alt;
    initial for (int i = 0; i < HW; i++) alt[i] = (i % 2 == 1);

    // Expected heater bank and parity, stepped from the expected heater_on waveform.
    logic [HW-1:0] mbank;
    bit            primed = 0;
    logic          mpar;
    bit            prev_h = 0;
    bit            in_frame = 0;
    frame_t        cur;

    always @(negedge clk) begin : mon
        int         t, b;
        logic       e_h, e_done, e_busy;
        logic [3:0] e_bi;
        logic [7:0] e_leds;
        if (cyc >= 1) begin
            if (rst_s) begin
                mbank  = '0;
                primed = 0;
                mpar   = 1'b0;
            end else begin
                mpar = ^mbank;
                if (prev_h) begin
                    mbank  = primed ? ~mbank : alt;
                    primed = 1;
                end
            end

            e_h = 0; e_done = 0; e_busy = 0; e_bi = 0; e_leds = 0;
            if (!in_frame && q.size() > 0 && q[0].acc == cyc - 1) begin
                cur      = q.pop_front();
                in_frame = 1;
            end
            if (in_frame) begin
                t = cyc - cur.acc;
                if (t <= cur.fin) begin
                    b      = (t - 1) / BC;
                    e_busy = 1;
                    e_leds = cur.d;
                    e_done = (t == T);
                    if (b < PLEN) begin
                        e_h  = PRE[PLEN-1-b];
                        e_bi = 4'(b);
                    end else if (b < PLEN + 8) begin
                        e_h  = cur.d[7-(b-PLEN)];
                        e_bi = 4'(b - PLEN);
                    end
                end else begin
                    in_frame = 0;
                end
            end

            chk("tx_ready",  32'(tx_ready),      32'(!e_busy));
            chk("busy",      32'(busy),          32'(e_busy));
            chk("done",      32'(done),          32'(e_done));
            chk("heater_on", 32'(heater_on),     32'(e_h));
            chk("bit_index", 32'(bit_index),     32'(e_bi));
            chk("leds",      32'(leds),          32'(e_leds));
            chk("parity",    32'(heater_parity), 32'(mpar));
            chk("bank",      32'(dut.u_bank.bank), 32'(mbank));
            prev_h = e_h;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit blk);
        for (int i = 0; i < n; i++) begin
            step();
            reset    = 1'b0;
            abort    = blk;
            tx_valid = blk;
            tx_data  = 8'($urandom);
        end
    endtask

    // kill>0 ends the frame early by abort (or reset if use_rst) in relative cycle kill.
    task automatic run_frame(input logic [7:0] d, input int kill, input bit use_rst,
                             input bit hold, input int stray, input logic [7:0] sd);
        frame_t f;
        step();
        reset    = 1'b0;
        abort    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        f.acc = cyc;
        f.d   = d;
        f.fin = (kill > 0) ? kill : T;
        q.push_back(f);
        for (int t = 1; t <= f.fin; t++) begin
            step();
            tx_valid = hold || (t == stray);
            tx_data  = (t == stray) ? sd : 8'($urandom);
            abort    = !use_rst && (t == kill);
            reset    = use_rst && (t == kill);
        end
    endtask

    initial begin
        int kill;
        step();
        step();
        idle(2, 0);
        run_frame(8'hA5, 0, 0, 0, 0, 8'h00);
        idle(1, 0);
        run_frame(8'h00, 0, 0, 1, 0, 8'h00);
        run_frame(8'hFF, 0, 0, 1, 0, 8'h00);
        idle(1, 0);
        run_frame(8'($urandom), PLEN*BC + 3*BC + int'($urandom_range(1, BC)), 0, 0, 0, 8'h00);
        run_frame(8'h3C, 0, 0, 0, 0, 8'h00);
        idle(2, 1);
        idle(1, 0);
        run_frame(8'hA5, 0, 0, 0, int'($urandom_range(1, PLEN*BC)), 8'h11);
        run_frame(8'($urandom), 20, 1, 0, 0, 8'h00);
        idle(6, 0);
        run_frame(8'($urandom), 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            kill = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T)) : 0;
            run_frame(8'($urandom), kill, (kill > 0) && ($urandom_range(0, 1) == 1),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, T)), 8'($urandom));
        end
        idle(3, 0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

endmodule
